// File: rtl/mem_wb_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_pkg
//   Shared definitions for the memory-access / write-back stage:
//   funct3 load/store size codes, the stage FSM encoding, and small helpers
//   for legality, alignment, byte-enable and store-lane generation.
// ---------------------------------------------------------------------------
package mem_wb_stage_pkg;

   // funct3 codes for loads and stores (stores use only B/H/W)
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_e;

   function automatic logic load_f3_ok(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   function automatic logic store_f3_ok(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
   endfunction

   // funct3[1:0] encodes the access size: 00 byte, 01 half, 10 word.
   function automatic logic aligned(input logic [1:0] size, input logic [1:0] a);
      logic ok;
      case (size)
         2'b00:   ok = 1'b1;
         2'b01:   ok = (a[0] == 1'b0);
         2'b10:   ok = (a == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] size_be(input logic [1:0] size, input logic [1:0] a);
      logic [3:0] be;
      case (size)
         2'b00:   be = 4'b0001 << a;
         2'b01:   be = 4'b0011 << a;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Store data is replicated across lanes so the byte enables alone pick
   // the destination bytes.
   function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
      logic [31:0] w;
      case (size)
         2'b00:   w = {4{d[7:0]}};
         2'b01:   w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_load_extend
//   Combinational load-data alignment: selects the byte/halfword at
//   addr_lo within the returned word and sign- or zero-extends it.
//   funct3  : load size/sign code
//   addr_lo : low two address bits of the access
//   rdata   : word returned by data memory
//   ext     : 32-bit value to write back
// ---------------------------------------------------------------------------
module mem_wb_stage_load_extend
   import mem_wb_stage_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   output logic [31:0] ext
);

   logic [31:0] shifted;

   always_comb begin
      // Bring the addressed byte/half down to bit 0 first.
      shifted = rdata >> {addr_lo, 3'b000};
      ext     = rdata;
      case (funct3)
         F3_B:    ext = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    ext = {{16{shifted[15]}}, shifted[15:0]};
         F3_BU:   ext = {24'h0, shifted[7:0]};
         F3_HU:   ext = {16'h0, shifted[15:0]};
         default: ext = rdata;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//   Memory-access and write-back stage. ALU results are written back one
//   cycle after acceptance; loads/stores run a req/ack transaction with a
//   timeout, and upstream is stalled (in_ready low) while it is in flight.
//
// Handshakes:
//   in_valid/in_ready : a transfer happens on a rising edge where both are 1;
//                       in_ready is 1 exactly when the FSM is IDLE.
//   dmem_req/dmem_ack : dmem_req is held with stable addr/be/wdata/we until a
//                       rising edge samples dmem_ack=1 (or the timeout
//                       expires); ack outside a request is ignored.
//   RegWrite, err     : single-cycle strobes.
//
// Ports:
//   CLK, RSTB              clock, async active-low reset
//   in_valid, in_ready     upstream handshake
//   Dmem1ALUOUT, DmemREB, DmemWEB, funct3, ALUOUT, rs2val, rd, InRegWrite
//                          EX result and control
//   dmem_req/we/addr/be/wdata, dmem_ack, dmem_rdata
//                          data-memory port
//   RegWrite, wb_rd, regfile_indata
//                          register-file write port
//   err                    misalign / illegal funct3 / timeout pulse
//   dbg_state              current FSM state
// ---------------------------------------------------------------------------
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 7
) (
   input  logic        CLK,
   input  logic        RSTB,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        Dmem1ALUOUT,
   input  logic        DmemREB,
   input  logic        DmemWEB,
   input  logic [2:0]  funct3,
   input  logic [31:0] ALUOUT,
   input  logic [31:0] rs2val,
   input  logic [4:0]  rd,
   input  logic        InRegWrite,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        RegWrite,
   output logic [4:0]  wb_rd,
   output logic [31:0] regfile_indata,
   output logic        err,
   output state_e      dbg_state
);

   state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic        dmem_req_q, dmem_req_d;
   logic        dmem_we_q, dmem_we_d;
   logic [31:0] dmem_addr_q, dmem_addr_d;
   logic [3:0]  dmem_be_q, dmem_be_d;
   logic [31:0] dmem_wdata_q, dmem_wdata_d;
   logic        regwrite_q, regwrite_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] indata_q, indata_d;
   logic        err_q, err_d;

   // Context of the outstanding access, needed to finish the write-back.
   logic [2:0]  f3_q, f3_d;
   logic [4:0]  rd_q, rd_d;
   logic        inregwrite_q, inregwrite_d;
   logic        from_mem_q, from_mem_d;
   logic [31:0] aluout_q, aluout_d;

   logic        is_mem;
   logic        is_store;
   logic        op_legal;
   logic        accept;
   logic        timeout;
   logic [31:0] load_ext;

   assign is_mem   = !DmemREB || !DmemWEB;
   assign is_store = !DmemWEB;          // store wins when both are low
   assign op_legal = (is_store ? store_f3_ok(funct3) : load_f3_ok(funct3)) &&
                     aligned(funct3[1:0], ALUOUT[1:0]);
   assign accept   = (state_q == IDLE) && in_valid;
   // Counter holds the number of ack-less cycles already spent; this cycle
   // would be the TIMEOUT_CYCLES-th.
   assign timeout  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   mem_wb_stage_load_extend u_load_extend (
      .funct3  (f3_q),
      .addr_lo (aluout_q[1:0]),
      .rdata   (dmem_rdata),
      .ext     (load_ext)
   );

   // ---------------- state register ----------------
   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_be_q    <= '0;
         dmem_wdata_q <= '0;
         regwrite_q   <= 1'b0;
         wb_rd_q      <= '0;
         indata_q     <= '0;
         err_q        <= 1'b0;
         f3_q         <= '0;
         rd_q         <= '0;
         inregwrite_q <= 1'b0;
         from_mem_q   <= 1'b0;
         aluout_q     <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         dmem_req_q   <= dmem_req_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_be_q    <= dmem_be_d;
         dmem_wdata_q <= dmem_wdata_d;
         regwrite_q   <= regwrite_d;
         wb_rd_q      <= wb_rd_d;
         indata_q     <= indata_d;
         err_q        <= err_d;
         f3_q         <= f3_d;
         rd_q         <= rd_d;
         inregwrite_q <= inregwrite_d;
         from_mem_q   <= from_mem_d;
         aluout_q     <= aluout_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && is_mem && op_legal) state_d = ACCESS;
         ACCESS:  if (dmem_ack || timeout) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- output / datapath logic ----------------
   always_comb begin
      cnt_d        = cnt_q;
      dmem_req_d   = dmem_req_q;
      dmem_we_d    = dmem_we_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_be_d    = dmem_be_q;
      dmem_wdata_d = dmem_wdata_q;
      regwrite_d   = 1'b0;
      wb_rd_d      = wb_rd_q;
      indata_d     = indata_q;
      err_d        = 1'b0;
      f3_d         = f3_q;
      rd_d         = rd_q;
      inregwrite_d = inregwrite_q;
      from_mem_d   = from_mem_q;
      aluout_d     = aluout_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (!is_mem) begin
                  regwrite_d = InRegWrite && (rd != 5'd0);
                  wb_rd_d    = rd;
                  indata_d   = ALUOUT;
               end else if (!op_legal) begin
                  err_d = 1'b1;
               end else begin
                  cnt_d        = '0;
                  dmem_req_d   = 1'b1;
                  dmem_we_d    = is_store;
                  dmem_addr_d  = {ALUOUT[31:2], 2'b00};
                  dmem_be_d    = size_be(funct3[1:0], ALUOUT[1:0]);
                  dmem_wdata_d = store_lanes(funct3[1:0], rs2val);
                  f3_d         = funct3;
                  rd_d         = rd;
                  inregwrite_d = InRegWrite;
                  from_mem_d   = Dmem1ALUOUT;
                  aluout_d     = ALUOUT;
               end
            end
         end
         ACCESS: begin
            if (dmem_ack) begin
               cnt_d      = '0;
               dmem_req_d = 1'b0;
               dmem_we_d  = 1'b0;
               if (!dmem_we_q) begin
                  regwrite_d = inregwrite_q && (rd_q != 5'd0);
                  wb_rd_d    = rd_q;
                  indata_d   = from_mem_q ? load_ext : aluout_q;
               end
            end else if (timeout) begin
               cnt_d      = '0;
               dmem_req_d = 1'b0;
               dmem_we_d  = 1'b0;
               err_d      = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign in_ready       = (state_q == IDLE);
   assign dmem_req       = dmem_req_q;
   assign dmem_we        = dmem_we_q;
   assign dmem_addr      = dmem_addr_q;
   assign dmem_be        = dmem_be_q;
   assign dmem_wdata     = dmem_wdata_q;
   assign RegWrite       = regwrite_q;
   assign wb_rd          = wb_rd_q;
   assign regfile_indata = indata_q;
   assign err            = err_q;
   assign dbg_state      = state_q;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access and write-back stage of the pipelined core.
- Consumes EX results plus control bits (Dmem1ALUOUT, DmemREB, DmemWEB, rd, RegWrite).
- Runs a variable-latency req/ack data-memory transaction and returns regfile_indata / RegWrite / rd to the register file write port.
- Stalls upstream while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 64: wait-for-ack cycles before abandoning an access; must be ≥1.
- CNT_W, 7: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  clock, rising edge.
- RSTB  in  1  asynchronous active-low reset.
- in_valid  in  1  EX result valid this cycle.
- in_ready  out  1  stage can accept; equals (state==IDLE).
- Dmem1ALUOUT  in  1  1 = write-back data from memory, 0 = from ALUOUT.
- DmemREB  in  1  active-low load request.
- DmemWEB  in  1  active-low store request.
- funct3  in  3  access size / sign.
- ALUOUT  in  32  ALU result, or effective address for memory ops.
- rs2val  in  32  store data.
- rd  in  5  destination register.
- InRegWrite  in  1  instruction writes rd.
- dmem_req  out  1  memory request, held until ack.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word-aligned address, {ALUOUT[31:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  transaction complete; rdata valid when !dmem_we.
- dmem_rdata  in  32  load word.
- RegWrite  out  1  one-cycle register write strobe.
- wb_rd  out  5  write address.
- regfile_indata  out  32  write data.
- err  out  1  one-cycle pulse on misalign, illegal funct3, or timeout.

Behaviour:
- Reset (RSTB low, async):
  - state=IDLE.
  - Outputs 0: dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, RegWrite, wb_rd, regfile_indata, err.
  - Timeout counter=0.
  - An in-flight access is dropped with no write-back; the bench must tolerate a late ack.
- States:
  - IDLE: accepts when in_valid.
  - ACCESS: dmem_req=1, counting.
  - IDLE is re-entered the cycle after ack or timeout.
- Accept in IDLE with both DmemREB and DmemWEB high:
  - Next cycle: RegWrite=InRegWrite&&(rd!=0), wb_rd=rd, regfile_indata=ALUOUT.
  - Stay IDLE, so one ALU op per cycle. Latency is 1.
- Store priority: DmemWEB low is a store regardless of DmemREB. DmemREB low alone is a load.
- Legality check at accept:
  - Loads: funct3 ∈ {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}.
  - Stores: funct3 ∈ {000 SB, 001 SH, 010 SW}.
  - Misaligned: halfword with ALUOUT[0]=1, or word with ALUOUT[1:0]≠0.
  - On an illegal or misaligned op: no request, no write-back, err=1 next cycle, stay IDLE.
- Legal memory op:
  - Next cycle: state=ACCESS, dmem_req=1, and addr/be/wdata/we latched.
  - Byte enables: SB 4'b0001<<a[1:0]; SH 4'b0011<<a[1:0]; SW 4'b1111.
  - Store data: SB {4{rs2[7:0]}}; SH {2{rs2[15:0]}}; SW rs2.
- ACCESS with dmem_ack sampled 1 (may be the first req cycle):
  - dmem_req=0 next cycle; state=IDLE.
  - Load: RegWrite=InRegWrite&&(rd!=0) the cycle after ack. Data is the selected byte/half at a[1:0] of dmem_rdata, sign-extended (LB/LH) or zero-extended (LBU/LHU). Load latency = 2 + ack wait.
  - Store: no RegWrite.
- Dmem1ALUOUT=0 on a load: write-back uses ALUOUT instead of memory data (the access still occurs).
- Timeout: counter increments each ACCESS cycle without ack. On reaching TIMEOUT_CYCLES: dmem_req=0, err=1, no write-back, IDLE.
- in_ready is low throughout ACCESS. Upstream holds its inputs, and they are ignored.
- RegWrite, err, and dmem_req are the only handshake strobes. All outputs are registered.

Decomposition:
- Shared package:
  - Load/store funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State encoding (IDLE, ACCESS).
- One natural sub-module: load_extend (combinational: funct3, addr[1:0], rdata → 32-bit extended value).

Test Plan:
- Three back-to-back ALU ops, rd=5/6/0, ALUOUT=0x11/0x22/0x33 → RegWrite pulses 1,1,0 on cycles 1–3, regfile_indata=0x11,0x22,0x33, in_ready stays 1.
- LB at 0x1003, ack after 3 cycles, rdata=0x80FF_0000 → dmem_addr=0x1000, be=0001<<3=1000, regfile_indata=0xFFFF_FF80, in_ready low 4 cycles.
- SH at 0x2002, rs2=0xABCD1234 → be=1100, wdata=0x12341234, no RegWrite; then LHU from same address with rdata=0x12340000 → 0x0000_1234.
- LW at 0x3001 → no dmem_req, err pulse next cycle, no RegWrite; funct3=011 load → same response.
- Load, ack never returns, TIMEOUT_CYCLES=4 → dmem_req high 4 cycles, then err pulse, IDLE; then RSTB pulsed low mid-ACCESS → all outputs 0 immediately, in_ready=1.
